// File: rtl/legv8_multicycle_control.sv
// -----------------------------------------------------------------------------
// legv8_multicycle_control
//
// Control FSM for a multicycle LEGv8 datapath. One ALU and one memory port are
// reused across cycles. The FSM reads the 11-bit opcode field from the
// instruction register and drives every mux select, write enable and ALU-op
// code. It waits on instruction/data memory ready handshakes, halts on
// unknown opcodes and exposes cycle/instruction counters for monitoring.
//
// Ports
//   iCLK, iRST            clock (rising edge), synchronous active-high reset
//   iOPCODE[10:0]         instruction bits [31:21] from the IR
//   iIMemReady            fetch data valid this cycle
//   iDMemReady            data read valid / write accepted this cycle
//   oIMemRead, oIRWrite   fetch request, IR load
//   oPCWrite, oPCWriteCond, oPCSource[1:0], oBranchType[1:0]   PC control
//   oALUSrcA, oALUSrcB[1:0], oALUop[1:0], oReg2Loc             ALU / regfile
//   oMemRead, oMemWrite, oMemToReg, oRegWrite                  memory / wb
//   oHalt                 illegal-opcode halt
//   oState[3:0]           current state code
//   oCycleCount, oInstrCount  free-running monitoring counters (wrap)
// -----------------------------------------------------------------------------
module legv8_multicycle_control (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [10:0] iOPCODE,
  input  logic        iIMemReady,
  input  logic        iDMemReady,
  output logic        oIMemRead,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oPCWriteCond,
  output logic [1:0]  oPCSource,
  output logic [1:0]  oBranchType,
  output logic        oALUSrcA,
  output logic [1:0]  oALUSrcB,
  output logic [1:0]  oALUop,
  output logic        oReg2Loc,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oMemToReg,
  output logic        oRegWrite,
  output logic        oHalt,
  output logic [3:0]  oState,
  output logic [31:0] oCycleCount,
  output logic [31:0] oInstrCount
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_WB_MEM    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_WB_ALU    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd15
  } state_t;

  typedef struct packed {
    logic       imem_read;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] branch_type;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg2loc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halt;
  } ctrl_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  function automatic state_t decode_next(input logic [10:0] op);
    if (op == OP_LDUR || op == OP_STUR)
      return S_MEM_ADDR;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
      return S_EXEC_R;
    // ADDI / SUBI: bit 0 of the field belongs to the immediate
    if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100)
      return S_EXEC_I;
    // CBZ / CBNZ / B.cond: low 3 bits belong to the offset
    if (op[10:3] == 8'b10110100 || op[10:3] == 8'b10110101 ||
        op[10:3] == 8'b01010100)
      return S_BRANCH;
    if (op[10:5] == 6'b000101)
      return S_JUMP;
    return S_HALT;
  endfunction

  function automatic logic [1:0] branch_type(input logic [10:0] op);
    case (op[10:3])
      8'b10110100: return 2'b01;
      8'b10110101: return 2'b10;
      8'b01010100: return 2'b11;
      default:     return 2'b00;
    endcase
  endfunction

  // Moore output table; opcode only matters for BranchType in BRANCH
  function automatic ctrl_t ctrl_for(input state_t s, input logic [10:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.imem_read = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.reg2loc   = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: c.mem_read = 1'b1;
      S_WB_MEM: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.reg2loc   = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
      end
      S_WB_ALU: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.reg2loc       = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch_type   = branch_type(op);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b01;
      end
      S_HALT:  c.halt = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_t      r_state;
  ctrl_t       r_ctrl;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  state_t      w_next;
  logic        w_instr_done;
  logic        w_fetch_go;
  ctrl_t       w_ctrl;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (iIMemReady) w_next = S_DECODE;
      S_DECODE:    w_next = decode_next(iOPCODE);
      S_MEM_ADDR: begin
        if (iOPCODE == OP_LDUR)      w_next = S_MEM_READ;
        else if (iOPCODE == OP_STUR) w_next = S_MEM_WRITE;
        else                         w_next = S_HALT;
      end
      S_MEM_READ:  if (iDMemReady) w_next = S_WB_MEM;
      S_MEM_WRITE: if (iDMemReady) w_next = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    w_next = S_WB_ALU;
      S_WB_MEM,
      S_WB_ALU,
      S_BRANCH,
      S_JUMP:      w_next = S_FETCH;
      default:     w_next = S_HALT;   // HALT absorbs, unused codes trap
    endcase
  end

  assign w_instr_done = (r_state == S_WB_MEM) || (r_state == S_WB_ALU) ||
                        (r_state == S_BRANCH) || (r_state == S_JUMP)   ||
                        ((r_state == S_MEM_WRITE) && iDMemReady);

  // Outputs for the next state are registered together with the state, so
  // every Moore output comes straight from a flop.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= S_FETCH;
      r_ctrl      <= ctrl_for(S_FETCH, iOPCODE);
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for(w_next, iOPCODE);
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_instr_done)      r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  // IR load and PC+4 commit only in the cycle the fetch data is valid
  assign w_fetch_go = (r_state == S_FETCH) && iIMemReady;

  // Reset forces every output low, including the cycle the reset is applied
  assign w_ctrl = iRST ? '0 : r_ctrl;

  assign oIMemRead    = w_ctrl.imem_read;
  assign oIRWrite     = !iRST && w_fetch_go;
  assign oPCWrite     = !iRST && (r_ctrl.pc_write || w_fetch_go);
  assign oPCWriteCond = w_ctrl.pc_write_cond;
  assign oPCSource    = w_ctrl.pc_source;
  assign oBranchType  = w_ctrl.branch_type;
  assign oALUSrcA     = w_ctrl.alu_src_a;
  assign oALUSrcB     = w_ctrl.alu_src_b;
  assign oALUop       = w_ctrl.alu_op;
  assign oReg2Loc     = w_ctrl.reg2loc;
  assign oMemRead     = w_ctrl.mem_read;
  assign oMemWrite    = w_ctrl.mem_write;
  assign oMemToReg    = w_ctrl.mem_to_reg;
  assign oRegWrite    = w_ctrl.reg_write;
  assign oHalt        = w_ctrl.halt;
  assign oState       = iRST ? 4'd0 : r_state;
  assign oCycleCount  = iRST ? 32'd0 : r_cycle_cnt;
  assign oInstrCount  = iRST ? 32'd0 : r_instr_cnt;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_legv8_multicycle_control
//
// Directed scenarios plus a randomized instruction stream. The reference model
// describes each instruction as a list of phases (state code, ready inputs to
// drive, whether the phase ends the instruction) and tracks the two counters
// as plain totals.
// -----------------------------------------------------------------------------
module tb_legv8_multicycle_control;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [10:0] iOPCODE;
  logic        iIMemReady;
  logic        iDMemReady;
  logic        oIMemRead, oIRWrite, oPCWrite, oPCWriteCond;
  logic [1:0]  oPCSource, oBranchType;
  logic        oALUSrcA;
  logic [1:0]  oALUSrcB, oALUop;
  logic        oReg2Loc, oMemRead, oMemWrite, oMemToReg, oRegWrite, oHalt;
  logic [3:0]  oState;
  logic [31:0] oCycleCount, oInstrCount;

  legv8_multicycle_control dut (
    .iCLK(iCLK), .iRST(iRST), .iOPCODE(iOPCODE),
    .iIMemReady(iIMemReady), .iDMemReady(iDMemReady),
    .oIMemRead(oIMemRead), .oIRWrite(oIRWrite), .oPCWrite(oPCWrite),
    .oPCWriteCond(oPCWriteCond), .oPCSource(oPCSource),
    .oBranchType(oBranchType), .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB),
    .oALUop(oALUop), .oReg2Loc(oReg2Loc), .oMemRead(oMemRead),
    .oMemWrite(oMemWrite), .oMemToReg(oMemToReg), .oRegWrite(oRegWrite),
    .oHalt(oHalt), .oState(oState), .oCycleCount(oCycleCount),
    .oInstrCount(oInstrCount)
  );

  always #5 iCLK = ~iCLK;

  logic [86:0] all_o;
  assign all_o = {oIMemRead, oIRWrite, oPCWrite, oPCWriteCond, oPCSource,
                  oBranchType, oALUSrcA, oALUSrcB, oALUop, oReg2Loc,
                  oMemRead, oMemWrite, oMemToReg, oRegWrite, oHalt, oState,
                  oCycleCount, oInstrCount};

  int nvec  = 0;
  int nfail = 0;

  // reference-model counters
  int unsigned mcyc;
  int unsigned minstr;

  // planned phases for the current instruction
  int q_st[$];
  int q_ir[$];   // -1 = don't care (driven randomly)
  int q_dr[$];
  int q_end[$];

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] ADD  = 11'b10001011000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void push(input int s, input int ir, input int dr, input int e);
    q_st.push_back(s);
    q_ir.push_back(ir);
    q_dr.push_back(dr);
    q_end.push_back(e);
  endfunction

  // kind: 0 LDUR, 1 STUR, 2 R-type, 3 I-type, 4 CB/B.cond, 5 B
  function automatic void plan(input int kind, input int wi, input int wd);
    for (int k = 0; k < wi; k++) push(0, 0, -1, 0);
    push(0, 1, -1, 0);
    push(1, -1, -1, 0);
    case (kind)
      0: begin
        push(2, -1, -1, 0);
        for (int k = 0; k < wd; k++) push(3, -1, 0, 0);
        push(3, -1, 1, 0);
        push(4, -1, -1, 1);
      end
      1: begin
        push(2, -1, -1, 0);
        for (int k = 0; k < wd; k++) push(5, -1, 0, 0);
        push(5, -1, 1, 1);
      end
      2, 3: begin
        push(kind == 2 ? 6 : 7, -1, -1, 0);
        push(8, -1, -1, 1);
      end
      4: push(9, -1, -1, 1);
      default: push(10, -1, -1, 1);
    endcase
  endfunction

  task automatic do_reset(input int n);
    iRST = 1'b1;
    repeat (n) @(posedge iCLK);
    #1;
    iRST   = 1'b0;
    mcyc   = 0;
    minstr = 0;
  endtask

  task automatic test_reset();
    iIMemReady = 1'b1;
    iDMemReady = 1'b1;
    iOPCODE    = ADD;
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLK);
      nvec++;
      if (all_o !== 87'd0) begin
        nfail++;
        $display("FAIL reset_outputs cycle %0d: got %h, want 0", k, all_o);
      end
      @(posedge iCLK); #1;
    end
    iRST = 1'b0;
    iIMemReady = 1'b0;
    @(negedge iCLK);
    nvec++;
    if (oState !== 4'd0 || oCycleCount !== 32'd0 || oInstrCount !== 32'd0) begin
      nfail++;
      $display("FAIL reset_release: state=%0d cyc=%0d instr=%0d, want 0/0/0",
               oState, oCycleCount, oInstrCount);
    end
    nvec++;
    if (oIMemRead !== 1'b1 || oALUSrcB !== 2'b01 || oIRWrite !== 1'b0) begin
      nfail++;
      $display("FAIL first_fetch: imemread=%b alusrcb=%b irwrite=%b, want 1/01/0",
               oIMemRead, oALUSrcB, oIRWrite);
    end
    // run into a load, then reset while the read is being accepted
    @(posedge iCLK); #1;
    iIMemReady = 1'b1;
    iOPCODE    = LDUR;
    iDMemReady = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    @(negedge iCLK);
    nvec++;
    if (oState !== 4'd3 || oMemRead !== 1'b1) begin
      nfail++;
      $display("FAIL pre_reset_memread: state=%0d memread=%b, want 3/1", oState, oMemRead);
    end
    @(posedge iCLK); #1;
    iRST = 1'b1;
    iDMemReady = 1'b1;
    @(negedge iCLK);
    nvec++;
    if (all_o !== 87'd0) begin
      nfail++;
      $display("FAIL midinstr_reset_outputs: got %h, want 0", all_o);
    end
    @(posedge iCLK); #1;
    iRST = 1'b0;
    iIMemReady = 1'b0;
    @(negedge iCLK);
    nvec++;
    if (oState !== 4'd0 || oRegWrite !== 1'b0 || oCycleCount !== 32'd0) begin
      nfail++;
      $display("FAIL midinstr_reset_release: state=%0d regwrite=%b cyc=%0d, want 0/0/0",
               oState, oRegWrite, oCycleCount);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_add();
    int exp_s[4] = '{0, 1, 6, 8};
    do_reset(2);
    iOPCODE = ADD; iIMemReady = 1'b1; iDMemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLK);
      nvec++;
      if (oState !== 4'(exp_s[k])) begin
        nfail++;
        $display("FAIL add_state cycle %0d: got %0d, want %0d", k, oState, exp_s[k]);
      end
      nvec++;
      if (oRegWrite !== 1'(k == 3)) begin
        nfail++;
        $display("FAIL add_regwrite cycle %0d: got %b, want %b", k, oRegWrite, k == 3);
      end
      if (k == 1) begin
        nvec++;
        if (oALUSrcB !== 2'b11 || oReg2Loc !== 1'b1 || oALUop !== 2'b00) begin
          nfail++;
          $display("FAIL decode_ctrl: alusrcb=%b reg2loc=%b aluop=%b, want 11/1/00",
                   oALUSrcB, oReg2Loc, oALUop);
        end
      end
      if (k == 2) begin
        nvec++;
        if (oALUop !== 2'b10 || oReg2Loc !== 1'b0 || oALUSrcA !== 1'b1) begin
          nfail++;
          $display("FAIL exec_r_ctrl: aluop=%b reg2loc=%b alusrca=%b, want 10/0/1",
                   oALUop, oReg2Loc, oALUSrcA);
        end
      end
      @(posedge iCLK); #1;
    end
    @(negedge iCLK);
    nvec++;
    if (oState !== 4'd0 || oInstrCount !== 32'd1 || oCycleCount !== 32'd4) begin
      nfail++;
      $display("FAIL add_done: state=%0d instr=%0d cyc=%0d, want 0/1/4",
               oState, oInstrCount, oCycleCount);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_ldur_wait();
    int exp_s[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    int rd_cnt = 0;
    do_reset(1);
    iOPCODE = LDUR; iIMemReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      iDMemReady = (k == 6);
      @(negedge iCLK);
      nvec++;
      if (oState !== 4'(exp_s[k])) begin
        nfail++;
        $display("FAIL ldur_state cycle %0d: got %0d, want %0d", k, oState, exp_s[k]);
      end
      if (oMemRead === 1'b1) rd_cnt++;
      if (k == 7) begin
        nvec++;
        if (oMemToReg !== 1'b1 || oRegWrite !== 1'b1) begin
          nfail++;
          $display("FAIL wb_mem_ctrl: memtoreg=%b regwrite=%b, want 1/1", oMemToReg, oRegWrite);
        end
      end
      @(posedge iCLK); #1;
    end
    nvec++;
    if (rd_cnt != 4) begin
      nfail++;
      $display("FAIL ldur_memread_cycles: got %0d, want 4", rd_cnt);
    end
    @(negedge iCLK);
    nvec++;
    if (oState !== 4'd0 || oCycleCount !== 32'd8 || oInstrCount !== 32'd1) begin
      nfail++;
      $display("FAIL ldur_done: state=%0d cyc=%0d instr=%0d, want 0/8/1",
               oState, oCycleCount, oInstrCount);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_stur_cbnz();
    int exp_a[4] = '{0, 1, 2, 5};
    int exp_b[3] = '{0, 1, 9};
    do_reset(1);
    iOPCODE = STUR; iIMemReady = 1'b1; iDMemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLK);
      nvec++;
      if (oState !== 4'(exp_a[k])) begin
        nfail++;
        $display("FAIL stur_state cycle %0d: got %0d, want %0d", k, oState, exp_a[k]);
      end
      if (k == 3) begin
        nvec++;
        if (oMemWrite !== 1'b1 || oReg2Loc !== 1'b1 || oRegWrite !== 1'b0) begin
          nfail++;
          $display("FAIL stur_ctrl: memwrite=%b reg2loc=%b regwrite=%b, want 1/1/0",
                   oMemWrite, oReg2Loc, oRegWrite);
        end
      end
      @(posedge iCLK); #1;
    end
    iOPCODE = {8'b10110101, 3'b101};
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLK);
      nvec++;
      if (oState !== 4'(exp_b[k])) begin
        nfail++;
        $display("FAIL cbnz_state cycle %0d: got %0d, want %0d", k, oState, exp_b[k]);
      end
      if (k == 2) begin
        nvec++;
        if (oPCWriteCond !== 1'b1 || oBranchType !== 2'b10 || oPCSource !== 2'b01 ||
            oALUop !== 2'b01 || oPCWrite !== 1'b0) begin
          nfail++;
          $display("FAIL cbnz_ctrl: pcwc=%b bt=%b pcsrc=%b aluop=%b pcw=%b, want 1/10/01/01/0",
                   oPCWriteCond, oBranchType, oPCSource, oALUop, oPCWrite);
        end
      end
      @(posedge iCLK); #1;
    end
    @(negedge iCLK);
    nvec++;
    if (oInstrCount !== 32'd2 || oCycleCount !== 32'd7) begin
      nfail++;
      $display("FAIL stur_cbnz_counts: instr=%0d cyc=%0d, want 2/7", oInstrCount, oCycleCount);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_b_fetch_wait();
    int exp_s[5] = '{0, 0, 0, 1, 10};
    int irw_cnt = 0;
    do_reset(1);
    iOPCODE = {6'b000101, 5'b10011}; iDMemReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iIMemReady = (k >= 2);
      @(negedge iCLK);
      nvec++;
      if (oState !== 4'(exp_s[k])) begin
        nfail++;
        $display("FAIL b_state cycle %0d: got %0d, want %0d", k, oState, exp_s[k]);
      end
      if (oIRWrite === 1'b1) irw_cnt++;
      if (k < 3) begin
        nvec++;
        if (oIRWrite !== 1'(k == 2) || oPCWrite !== 1'(k == 2)) begin
          nfail++;
          $display("FAIL fetch_strobe cycle %0d: irwrite=%b pcwrite=%b, want %b",
                   k, oIRWrite, oPCWrite, k == 2);
        end
      end
      if (k == 4) begin
        nvec++;
        if (oPCWrite !== 1'b1 || oPCSource !== 2'b01 || oPCWriteCond !== 1'b0) begin
          nfail++;
          $display("FAIL jump_ctrl: pcwrite=%b pcsrc=%b pcwc=%b, want 1/01/0",
                   oPCWrite, oPCSource, oPCWriteCond);
        end
      end
      @(posedge iCLK); #1;
    end
    nvec++;
    if (irw_cnt != 1) begin
      nfail++;
      $display("FAIL irwrite_pulses: got %0d, want 1", irw_cnt);
    end
  endtask

  task automatic test_halt();
    int exp_s[5] = '{0, 1, 15, 15, 15};
    do_reset(1);
    iOPCODE = 11'b11111111111; iIMemReady = 1'b1; iDMemReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge iCLK);
      nvec++;
      if (oState !== 4'(exp_s[k])) begin
        nfail++;
        $display("FAIL halt_state cycle %0d: got %0d, want %0d", k, oState, exp_s[k]);
      end
      if (k >= 2) begin
        nvec++;
        if (oHalt !== 1'b1 || oCycleCount !== 32'd2 || oInstrCount !== 32'd0 ||
            oIMemRead !== 1'b0 || oPCWrite !== 1'b0 || oIRWrite !== 1'b0) begin
          nfail++;
          $display("FAIL halt_freeze cycle %0d: halt=%b cyc=%0d instr=%0d imr=%b pcw=%b irw=%b, want 1/2/0/0/0/0",
                   k, oHalt, oCycleCount, oInstrCount, oIMemRead, oPCWrite, oIRWrite);
        end
      end
      @(posedge iCLK); #1;
    end
    do_reset(1);
    iIMemReady = 1'b0;
    @(negedge iCLK);
    nvec++;
    if (oState !== 4'd0 || oHalt !== 1'b0 || oCycleCount !== 32'd0 || oInstrCount !== 32'd0) begin
      nfail++;
      $display("FAIL halt_exit: state=%0d halt=%b cyc=%0d instr=%0d, want 0/0/0/0",
               oState, oHalt, oCycleCount, oInstrCount);
    end
    @(posedge iCLK); #1;
  endtask

  task automatic test_random();
    logic [10:0] rlist[4] = '{11'b10001011000, 11'b11001011000,
                              11'b10001010000, 11'b10101010000};
    logic [10:0] op;
    logic [1:0]  bt;
    int sel, kind, st, ir, dr, en;
    do_reset(1);
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 7));
      bt  = 2'b00;
      case (sel)
        0: begin kind = 0; op = LDUR; end
        1: begin kind = 1; op = STUR; end
        2: begin kind = 2; op = rlist[$urandom_range(0, 3)]; end
        3: begin kind = 3; op = {($urandom_range(0, 1) != 0) ? 10'b1101000100 : 10'b1001000100, 1'($urandom)}; end
        4: begin kind = 4; op = {8'b10110100, 3'($urandom)}; bt = 2'b01; end
        5: begin kind = 4; op = {8'b10110101, 3'($urandom)}; bt = 2'b10; end
        6: begin kind = 4; op = {8'b01010100, 3'($urandom)}; bt = 2'b11; end
        default: begin kind = 5; op = {6'b000101, 5'($urandom)}; end
      endcase
      plan(kind, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      while (q_st.size() > 0) begin
        st = q_st.pop_front();
        ir = q_ir.pop_front();
        dr = q_dr.pop_front();
        en = q_end.pop_front();
        iOPCODE    = op;
        iIMemReady = (ir < 0) ? 1'($urandom) : (ir == 1);
        iDMemReady = (dr < 0) ? 1'($urandom) : (dr == 1);
        @(negedge iCLK);
        nvec++;
        if (oState !== 4'(st)) begin
          nfail++;
          $display("FAIL rnd_state instr %0d op %b: got %0d, want %0d", n, op, oState, st);
        end
        nvec++;
        if (oRegWrite !== 1'(st == 4 || st == 8) || oMemRead !== 1'(st == 3) ||
            oMemWrite !== 1'(st == 5) || oHalt !== 1'b0 ||
            oIRWrite !== 1'(st == 0 && iIMemReady) ||
            oPCWrite !== 1'((st == 0 && iIMemReady) || st == 10)) begin
          nfail++;
          $display("FAIL rnd_strobes instr %0d state %0d: rw=%b mr=%b mw=%b h=%b irw=%b pcw=%b",
                   n, st, oRegWrite, oMemRead, oMemWrite, oHalt, oIRWrite, oPCWrite);
        end
        if (st == 9) begin
          nvec++;
          if (oBranchType !== bt) begin
            nfail++;
            $display("FAIL rnd_branchtype op %b: got %b, want %b", op, oBranchType, bt);
          end
        end
        nvec++;
        if (oCycleCount !== mcyc || oInstrCount !== minstr) begin
          nfail++;
          $display("FAIL rnd_counters instr %0d: cyc=%0d instr=%0d, want %0d/%0d",
                   n, oCycleCount, oInstrCount, mcyc, minstr);
        end
        @(posedge iCLK); #1;
        if (st != 15) mcyc++;
        if (en != 0) minstr++;
      end
    end
  endtask

  initial begin
    iRST       = 1'b1;
    iOPCODE    = '0;
    iIMemReady = 1'b0;
    iDMemReady = 1'b0;
    @(posedge iCLK); #1;
    test_reset();
    test_add();
    test_ldur_wait();
    test_stur_cbnz();
    test_b_fetch_wait();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
